// File: rtl/mcrc_check.sv
`default_nettype none
// ============================================================================
//  Module   : mcrc_check
//  Purpose  : Receive-side serial CRC checker. Accepts LEN payload bits and
//             then MSB+1 transmitted CRC bits (MSB first). The payload is run
//             through the same runtime-configurable LFSR update as the serial
//             generator. The received CRC is captured and compared with the
//             computed value, and the result is reported when the frame ends.
//  Ports    : clk, rstb (async, active-low)
//             start    - begin a frame and sample ini/tap/msb/len
//             bit_vld  - x carries a bit this cycle
//             x        - serial data bit
//             ini/tap  - LFSR initial value / polynomial taps
//             msb      - active CRC width minus one (clamped to MAX_WIDTH-1)
//             len      - payload length in bits (0 allowed)
//             busy     - frame in progress
//             done     - one-cycle pulse, results valid
//             ok       - crc_rx == crc_calc for the last completed frame
//             abort    - one-cycle pulse, start seen while busy
//             crc_calc - computed CRC, crc_rx - received CRC
//  Revision : 1.0  initial release
// ============================================================================
module mcrc_check #(
    parameter int MAX_WIDTH = 32,
    parameter int LEN_W     = 16
) (
    input  logic                           clk,
    input  logic                           rstb,
    input  logic                           start,
    input  logic                           bit_vld,
    input  logic                           x,
    input  logic [MAX_WIDTH-1:0]           ini,
    input  logic [MAX_WIDTH-1:0]           tap,
    input  logic [$clog2(MAX_WIDTH):0]     msb,
    input  logic [LEN_W-1:0]               len,
    output logic                           busy,
    output logic                           done,
    output logic                           ok,
    output logic                           abort,
    output logic [MAX_WIDTH-1:0]           crc_calc,
    output logic [MAX_WIDTH-1:0]           crc_rx
);

    localparam int IDX_W = $clog2(MAX_WIDTH);
    localparam int MSB_W = IDX_W + 1;

    localparam logic [MSB_W-1:0] c_max_width = MSB_W'(MAX_WIDTH);
    localparam logic [IDX_W-1:0] c_top_idx   = IDX_W'(MAX_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PAY  = 2'd1,
        S_CRC  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [LEN_W-1:0]     r_len;
    logic [LEN_W-1:0]     r_pay_cnt;
    logic [MSB_W-1:0]     r_crc_cnt;
    logic [IDX_W-1:0]     r_msb;
    logic [MAX_WIDTH-1:0] r_mask;
    logic [MAX_WIDTH-1:0] r_tap;
    logic [MAX_WIDTH-1:0] r_sum;
    logic [MAX_WIDTH-1:0] r_crc_rx;
    logic [MAX_WIDTH-1:0] r_crc_calc;
    logic                 r_ok;
    logic                 r_done;
    logic                 r_abort;

    logic [IDX_W-1:0]     w_msb_clamped;
    logic [MSB_W-1:0]     w_width_in;
    logic [MAX_WIDTH-1:0] w_mask_in;
    logic                 w_accept;
    logic                 w_pay_acc;
    logic                 w_crc_acc;
    logic                 w_pay_last;
    logic                 w_crc_last;
    logic                 w_sum_top;
    logic                 w_fb;
    logic [MAX_WIDTH-1:0] w_sum_nxt;
    logic [MAX_WIDTH-1:0] w_rx_nxt;

    // Configuration decode for the frame being started.
    assign w_msb_clamped = (msb >= c_max_width) ? c_top_idx : msb[IDX_W-1:0];
    assign w_width_in    = {1'b0, w_msb_clamped} + MSB_W'(1);
    // Shifting all-ones by the full width yields zero, so a full-width CRC
    // gets an all-ones mask without a special case.
    assign w_mask_in     = ~({MAX_WIDTH{1'b1}} << w_width_in);

    // A bit arriving together with start belongs to no frame and is dropped.
    assign w_accept   = bit_vld && !start && (r_state != S_IDLE);
    assign w_pay_acc  = w_accept && (r_state == S_PAY);
    assign w_crc_acc  = w_accept && (r_state == S_CRC);
    assign w_pay_last = w_pay_acc && (r_pay_cnt == (r_len - LEN_W'(1)));
    assign w_crc_last = w_crc_acc && (r_crc_cnt == {1'b0, r_msb});

    // LFSR step, identical to the generator: feedback into bit 0, taps
    // applied whenever the outgoing top bit is set.
    assign w_sum_top = r_sum[r_msb];
    assign w_fb      = w_sum_top ^ x;
    assign w_sum_nxt = ({r_sum[MAX_WIDTH-2:0], w_fb} ^ (w_sum_top ? r_tap : '0)) & r_mask;

    // Received CRC shift register, confined to the active width.
    assign w_rx_nxt  = {r_crc_rx[MAX_WIDTH-2:0], x} & r_mask;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = (len == '0) ? S_CRC : S_PAY;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_IDLE;
                S_PAY:   if (w_pay_last) w_state_nxt = S_CRC;
                S_CRC:   if (w_crc_last) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath, counters and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_len      <= '0;
            r_pay_cnt  <= '0;
            r_crc_cnt  <= '0;
            r_msb      <= '0;
            r_mask     <= '0;
            r_tap      <= '0;
            r_sum      <= '0;
            r_crc_rx   <= '0;
            r_crc_calc <= '0;
            r_ok       <= 1'b0;
            r_done     <= 1'b0;
            r_abort    <= 1'b0;
        end else if (start) begin
            r_len     <= len;
            r_msb     <= w_msb_clamped;
            r_mask    <= w_mask_in;
            r_tap     <= tap;
            r_sum     <= ini & w_mask_in;
            r_crc_rx  <= '0;
            r_pay_cnt <= '0;
            r_crc_cnt <= '0;
            r_done    <= 1'b0;
            // Restarting over a live frame discards it silently apart
            // from this pulse.
            r_abort   <= (r_state != S_IDLE);
        end else begin
            r_abort <= 1'b0;
            r_done  <= w_crc_last;
            if (w_pay_acc) begin
                r_sum <= w_sum_nxt;
                if (!w_pay_last) begin
                    r_pay_cnt <= r_pay_cnt + LEN_W'(1);
                end
            end
            if (w_crc_acc) begin
                r_crc_rx <= w_rx_nxt;
                if (w_crc_last) begin
                    r_crc_calc <= r_sum;
                    r_ok       <= (w_rx_nxt == r_sum);
                end else begin
                    r_crc_cnt <= r_crc_cnt + MSB_W'(1);
                end
            end
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign ok       = r_ok;
    assign abort    = r_abort;
    assign crc_calc = r_crc_calc;
    assign crc_rx   = r_crc_rx;

endmodule
`default_nettype wire
